line_fetch_sequencer: RTL and testbench

Draw-clock controller that sequences the per-line tile fetch for the draw pipeline. It replaces the free-running address/counter stage with an explicit state machine. On each synchronized line pulse it:
- flushes the downstream pipeline stages,
- issues exactly WORDS_PER_LINE fetch beats (tile map coordinates, tile row/column, line-buffer x, buffer select),
- honours back-pressure from downstream,
- reports completion or overrun.

---
 rtl/line_fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_line_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_sequencer.sv
// Per-line tile fetch sequencer on the draw clock: flush, WORDS_PER_LINE beats, done/overrun.
// Optional stall statistics counter enabled by `define LINE_FETCH_STALL_STATS_EN.
module line_fetch_sequencer #(
  parameter int CORDW          = 11,
  parameter int WORDS_PER_LINE = 80,
  parameter int CNTW           = 7
) (
  input  logic             clk_draw,
  input  logic             rst_draw_n,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [CORDW-1:0] line_y,
  input  logic [11:0]      scroll_x,
  input  logic             stall,
  output logic             fetch_valid,
  output logic [4:0]       tile_map_x,
  output logic [4:0]       tile_map_y,
  output logic [2:0]       tile_row,
  output logic             tile_col,
  output logic [11:0]      lb_x,
  output logic             bufsel,
  output logic             pipe_flush,
  output logic             busy,
  output logic             line_done,
  output logic             overrun,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {IDLE, FLUSH, FETCH, DONE} state_t;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(WORDS_PER_LINE - 1);

  state_t          state;
  logic [11:0]     scroll_q;
  logic [11:0]     x_p0;
  logic [CNTW-1:0] cnt_p0;
  logic [11:0]     line_scroll;

  // A frame_start coinciding with line_start must already apply to that line.
  assign line_scroll = frame_start ? scroll_x : scroll_q;

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state       <= IDLE;
      scroll_q    <= '0;
      x_p0        <= '0;
      cnt_p0      <= '0;
      fetch_valid <= 1'b0;
      tile_map_x  <= '0;
      tile_map_y  <= '0;
      tile_row    <= '0;
      tile_col    <= 1'b0;
      lb_x        <= '0;
      bufsel      <= 1'b0;
      pipe_flush  <= 1'b0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pipe_flush  <= 1'b0;
      line_done   <= 1'b0;
      overrun     <= 1'b0;
      fetch_valid <= 1'b0;
      if (frame_start)
        scroll_q <= scroll_x;
      // A new line always restarts from FLUSH; arriving mid-line it aborts the old one.
      if (line_start) begin
        overrun    <= (state != IDLE);
        state      <= FLUSH;
        busy       <= 1'b1;
        bufsel     <= line_y[0];
        tile_map_y <= line_y[8:4];
        tile_row   <= line_y[3:1];
        lb_x       <= line_scroll;
        x_p0       <= line_scroll;
        cnt_p0     <= '0;
      end else begin
        case (state)
          FLUSH: begin
            pipe_flush <= 1'b1;
            state      <= FETCH;
          end
          FETCH: begin
            if (!stall) begin
              fetch_valid <= 1'b1;
              tile_map_x  <= cnt_p0[5:1];
              tile_col    <= cnt_p0[0];
              lb_x        <= x_p0;
              x_p0        <= x_p0 + 12'd8;
              cnt_p0      <= cnt_p0 + CNTW'(1);
              if (cnt_p0 == LAST_BEAT)
                state <= DONE;
            end
          end
          DONE: begin
            line_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LINE_FETCH_STALL_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Clear wins over a simultaneous stall count.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n)
      stall_cycles <= '0;
    else if (frame_start)
      stall_cycles <= '0;
    else if (state == FETCH && stall)
      stall_cycles <= sat_inc16(stall_cycles);
  end
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_line_fetch_sequencer.sv
// Directed bench for line_fetch_sequencer: full lines, scroll wrap, stall, overrun, mid-line reset.
module tb_line_fetch_sequencer;

  logic        clk_draw = 1'b0;
  logic        rst_draw_n = 1'b0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] line_y = '0;
  logic [11:0] scroll_x = '0;
  logic        stall = 1'b0;
  logic        fetch_valid;
  logic [4:0]  tile_map_x;
  logic [4:0]  tile_map_y;
  logic [2:0]  tile_row;
  logic        tile_col;
  logic [11:0] lb_x;
  logic        bufsel;
  logic        pipe_flush;
  logic        busy;
  logic        line_done;
  logic        overrun;
  logic [15:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  line_fetch_sequencer #(.CORDW(11), .WORDS_PER_LINE(80), .CNTW(7)) dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .line_start(line_start),
    .frame_start(frame_start), .line_y(line_y), .scroll_x(scroll_x), .stall(stall),
    .fetch_valid(fetch_valid), .tile_map_x(tile_map_x), .tile_map_y(tile_map_y),
    .tile_row(tile_row), .tile_col(tile_col), .lb_x(lb_x), .bufsel(bufsel),
    .pipe_flush(pipe_flush), .busy(busy), .line_done(line_done), .overrun(overrun),
    .stall_cycles(stall_cycles)
  );

  always #5 clk_draw = ~clk_draw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_draw);
    #1;
  endtask

  function automatic logic [27:0] beat_vec(input logic vld, input int i, input logic [4:0] my,
                                           input logic [2:0] row, input logic bs,
                                           input logic [11:0] base);
    logic [6:0]  c;
    logic [11:0] x;
    c = 7'(i);
    x = base + 12'(8 * i);
    return {vld, c[5:1], c[0], x, my, row, bs};
  endfunction

  function automatic logic [63:0] all_outs();
    return {16'd0, fetch_valid, tile_map_x, tile_map_y, tile_row, tile_col, lb_x, bufsel,
            pipe_flush, busy, line_done, overrun, stall_cycles};
  endfunction

  task automatic start_line(input logic [10:0] y);
    line_start = 1'b1;
    line_y = y;
    tick();
    line_start = 1'b0;
  endtask

  task automatic load_scroll(input logic [11:0] s);
    scroll_x = s;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Called just after the edge that sampled line_start; runs the line to line_done.
  task automatic run_line(input logic [4:0] my, input logic [2:0] row, input logic bs,
                          input logic [11:0] base, input int stall_at, input int stall_len);
    int cycles;
    int i;
    int rem;
    logic st;
    chk("flush_early", {62'd0, pipe_flush, busy}, 64'h1);
    tick();
    chk("flush_pulse", {61'd0, pipe_flush, fetch_valid, overrun}, 64'h4);
    cycles = 1;
    i = 0;
    rem = stall_len;
    while (i < 80 && cycles < 400) begin
      st = (i == stall_at) && (rem > 0);
      stall = st;
      tick();
      cycles++;
      chk("no_early_done", {63'd0, line_done | pipe_flush}, 64'h0);
      if (st) begin
        rem--;
        chk("stall_hold", {36'd0, fetch_valid, tile_map_x, tile_col, lb_x, tile_map_y, tile_row, bufsel},
            {36'd0, beat_vec(1'b0, i - 1, my, row, bs, base)});
      end else begin
        chk("beat", {36'd0, fetch_valid, tile_map_x, tile_col, lb_x, tile_map_y, tile_row, bufsel},
            {36'd0, beat_vec(1'b1, i, my, row, bs, base)});
        i++;
      end
    end
    stall = 1'b0;
    chk("beat_count", 64'(i), 64'd80);
    tick();
    cycles++;
    chk("done_pulse", {61'd0, line_done, busy, fetch_valid}, 64'h4);
    chk("line_cycles", 64'(cycles), 64'(82 + stall_len));
    tick();
    chk("done_one_cycle", {63'd0, line_done}, 64'h0);
  endtask

  initial begin
    logic [15:0] exp_stats;

    // Reset state
    #12;
    chk("reset_outs", all_outs(), 64'h0);
    tick();
    rst_draw_n = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 64'h0);

    // Basic line, scroll 0
    load_scroll(12'h000);
    start_line(11'h035);
    run_line(5'd3, 3'd2, 1'b1, 12'h000, -1, 0);
    chk("last_fields", {45'd0, tile_map_x, tile_col, lb_x, bufsel}, {45'd0, 5'd7, 1'b1, 12'd632, 1'b1});

    // Scroll near the top of the line buffer wraps
    load_scroll(12'hFFC);
    start_line(11'h035);
    run_line(5'd3, 3'd2, 1'b1, 12'hFFC, -1, 0);

    // frame_start coinciding with line_start uses the new scroll
    scroll_x = 12'h100;
    frame_start = 1'b1;
    start_line(11'h053);
    frame_start = 1'b0;
    run_line(5'd5, 3'd1, 1'b1, 12'h100, -1, 0);

    // Five stall cycles after beat 10
    load_scroll(12'h000);
    start_line(11'h035);
    run_line(5'd3, 3'd2, 1'b1, 12'h000, 11, 5);
`ifdef LINE_FETCH_STALL_STATS_EN
    exp_stats = 16'd5;
`else
    exp_stats = 16'd0;
`endif
    chk("stats_after_stall", 64'(stall_cycles), 64'(exp_stats));

    // Overrun during beat 40
    start_line(11'h035);
    tick();
    for (int k = 0; k < 40; k++) tick();
    chk("pre_overrun_beat", {57'd0, fetch_valid, tile_map_x, tile_col}, {57'd0, 1'b1, 5'd19, 1'b1});
    start_line(11'h036);
    chk("overrun_pulse", {61'd0, overrun, fetch_valid, busy}, 64'h5);
    run_line(5'd3, 3'd3, 1'b0, 12'h000, -1, 0);
    chk("overrun_cleared", {63'd0, overrun}, 64'h0);

    // Asynchronous reset in the middle of a line
    load_scroll(12'h040);
    start_line(11'h035);
    tick();
    for (int k = 0; k < 20; k++) tick();
    chk("pre_reset_busy", {62'd0, busy, fetch_valid}, 64'h3);
    #2;
    rst_draw_n = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 64'h0);
    tick();
    tick();
    chk("reset_held_outs", all_outs(), 64'h0);
    #3;
    rst_draw_n = 1'b1;
    tick();
    start_line(11'h035);
    run_line(5'd3, 3'd2, 1'b1, 12'h000, -1, 0);

    // Stall statistics: idle stalls ignored, FETCH stalls counted, frame_start clears
    load_scroll(12'h000);
    stall = 1'b1;
    tick();
    tick();
    tick();
    stall = 1'b0;
    chk("stats_idle_stall", 64'(stall_cycles), 64'h0);
    start_line(11'h035);
    run_line(5'd3, 3'd2, 1'b1, 12'h000, 11, 7);
`ifdef LINE_FETCH_STALL_STATS_EN
    exp_stats = 16'd7;
`else
    exp_stats = 16'd0;
`endif
    chk("stats_fetch_stall", 64'(stall_cycles), 64'(exp_stats));
    load_scroll(12'h000);
    chk("stats_cleared", 64'(stall_cycles), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
